// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter that merges WB-stage writes with MDU results held in a 2-entry buffer.
// Zero-latency grant, combinational from state; the MDU is backpressured via mdu_ready_out when the buffer is full; WB is stalled only when starvation forces the buffer head.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_regwrite_in,
  input  logic [4:0]  pipe_rd_in,
  input  logic [31:0] pipe_wdata_in,
  input  logic        mdu_valid_in,
  input  logic [4:0]  mdu_rd_in,
  input  logic [31:0] mdu_wdata_in,
  output logic        mdu_ready_out,
  input  logic [4:0]  chk_rs1_in,
  input  logic [4:0]  chk_rs2_in,
  input  logic [4:0]  chk_rd_in,
  output logic        hazard_out,
  output logic        pipe_stall_out,
  output logic        rf_we_out,
  output logic [4:0]  rf_waddr_out,
  output logic [31:0] rf_wdata_out,
  output logic [1:0]  pending_count_out
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT - 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_HEAD,
    SRC_BYP
  } src_e;

  entry_t     fifo_q [2];
  logic [1:0] count;
  logic [3:0] starve_cnt;

  logic   pipe_eff;
  logic   mdu_hs;
  logic   mdu_nz;
  logic   fifo_ne;
  logic   starved;
  src_e   grant;
  logic   pop;
  logic   push;
  entry_t mdu_entry;

  function automatic logic chk_hit(input logic [4:0] rd);
    return (chk_rs1_in != 5'd0 && rd == chk_rs1_in) ||
           (chk_rs2_in != 5'd0 && rd == chk_rs2_in) ||
           (chk_rd_in  != 5'd0 && rd == chk_rd_in);
  endfunction

  assign pipe_eff      = pipe_regwrite_in && (pipe_rd_in != 5'd0);
  assign mdu_ready_out = !reset && (count != 2'd2);
  assign mdu_hs        = mdu_valid_in && mdu_ready_out;
  assign mdu_nz        = mdu_hs && (mdu_rd_in != 5'd0);
  assign fifo_ne       = (count != 2'd0);
  assign starved       = fifo_ne && (starve_cnt == STARVE_MAX);
  assign mdu_entry     = '{rd: mdu_rd_in, data: mdu_wdata_in};

  always_comb begin
    grant = SRC_NONE;
    if (reset)         grant = SRC_NONE;
    else if (starved)  grant = SRC_HEAD;
    else if (pipe_eff) grant = SRC_PIPE;
    else if (fifo_ne)  grant = SRC_HEAD;
    else if (mdu_nz)   grant = SRC_BYP;
  end

  assign pop            = (grant == SRC_HEAD);
  assign push           = mdu_nz && (grant != SRC_BYP);
  assign pipe_stall_out = !reset && pipe_eff && starved;

  always_comb begin
    rf_we_out    = 1'b0;
    rf_waddr_out = 5'd0;
    rf_wdata_out = 32'd0;
    case (grant)
      SRC_PIPE: begin
        rf_we_out    = 1'b1;
        rf_waddr_out = pipe_rd_in;
        rf_wdata_out = pipe_wdata_in;
      end
      SRC_HEAD: begin
        rf_we_out    = 1'b1;
        rf_waddr_out = fifo_q[0].rd;
        rf_wdata_out = fifo_q[0].data;
      end
      SRC_BYP: begin
        rf_we_out    = 1'b1;
        rf_waddr_out = mdu_rd_in;
        rf_wdata_out = mdu_wdata_in;
      end
      default: ;
    endcase
  end

  // Only entries below the count are live; stale slots must not raise a hazard.
  assign hazard_out = ((count != 2'd0) && chk_hit(fifo_q[0].rd)) ||
                      ((count == 2'd2) && chk_hit(fifo_q[1].rd));

  assign pending_count_out = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      count      <= 2'd0;
      starve_cnt <= 4'd0;
    end else begin
      if (push && pop) begin
        if (count == 2'd2) begin
          fifo_q[0] <= fifo_q[1];
          fifo_q[1] <= mdu_entry;
        end else begin
          fifo_q[0] <= mdu_entry;
        end
      end else if (push) begin
        if (count == 2'd0) fifo_q[0] <= mdu_entry;
        else               fifo_q[1] <= mdu_entry;
        count <= count + 2'd1;
      end else if (pop) begin
        fifo_q[0] <= fifo_q[1];
        count     <= count - 2'd1;
      end

      // Counts only cycles where a buffered head was passed over.
      if (pop || !fifo_ne)
        starve_cnt <= 4'd0;
      else if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter with a short starvation limit.
module tb_wb_port_arbiter;

  localparam int SL = 4;

  logic        clk;
  logic        reset;
  logic        pipe_regwrite_in;
  logic [4:0]  pipe_rd_in;
  logic [31:0] pipe_wdata_in;
  logic        mdu_valid_in;
  logic [4:0]  mdu_rd_in;
  logic [31:0] mdu_wdata_in;
  logic        mdu_ready_out;
  logic [4:0]  chk_rs1_in;
  logic [4:0]  chk_rs2_in;
  logic [4:0]  chk_rd_in;
  logic        hazard_out;
  logic        pipe_stall_out;
  logic        rf_we_out;
  logic [4:0]  rf_waddr_out;
  logic [31:0] rf_wdata_out;
  logic [1:0]  pending_count_out;

  wb_port_arbiter #(.STARVE_LIMIT(SL)) dut (
    .clk               (clk),
    .reset             (reset),
    .pipe_regwrite_in  (pipe_regwrite_in),
    .pipe_rd_in        (pipe_rd_in),
    .pipe_wdata_in     (pipe_wdata_in),
    .mdu_valid_in      (mdu_valid_in),
    .mdu_rd_in         (mdu_rd_in),
    .mdu_wdata_in      (mdu_wdata_in),
    .mdu_ready_out     (mdu_ready_out),
    .chk_rs1_in        (chk_rs1_in),
    .chk_rs2_in        (chk_rs2_in),
    .chk_rd_in         (chk_rd_in),
    .hazard_out        (hazard_out),
    .pipe_stall_out    (pipe_stall_out),
    .rf_we_out         (rf_we_out),
    .rf_waddr_out      (rf_waddr_out),
    .rf_wdata_out      (rf_wdata_out),
    .pending_count_out (pending_count_out)
  );

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall;
    logic [1:0]  cnt;
    logic        rdy;
    logic        haz;
  } exp_t;

  exp_t  exp_q [$];
  string tag_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are combinational, so each cycle is judged a little after the driving edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq({t, ".we"},    32'(rf_we_out),         32'(e.we));
        check_eq({t, ".addr"},  32'(rf_waddr_out),      32'(e.addr));
        check_eq({t, ".data"},  rf_wdata_out,           e.data);
        check_eq({t, ".stall"}, 32'(pipe_stall_out),    32'(e.stall));
        check_eq({t, ".cnt"},   32'(pending_count_out), 32'(e.cnt));
        check_eq({t, ".rdy"},   32'(mdu_ready_out),     32'(e.rdy));
        check_eq({t, ".haz"},   32'(hazard_out),        32'(e.haz));
      end
    end
  end

  task automatic cyc(
    input string tag, input logic rs,
    input logic pw, input logic [4:0] prd, input logic [31:0] pd,
    input logic mv, input logic [4:0] mrd, input logic [31:0] md,
    input logic [4:0] c1, input logic [4:0] c2, input logic [4:0] c3,
    input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
    input logic est, input logic [1:0] ec, input logic erd, input logic ehz);
    exp_t e;
    @(negedge clk);
    reset            = rs;
    pipe_regwrite_in = pw;
    pipe_rd_in       = prd;
    pipe_wdata_in    = pd;
    mdu_valid_in     = mv;
    mdu_rd_in        = mrd;
    mdu_wdata_in     = md;
    chk_rs1_in       = c1;
    chk_rs2_in       = c2;
    chk_rd_in        = c3;
    e.we = ewe; e.addr = ea; e.data = ed; e.stall = est;
    e.cnt = ec; e.rdy = erd; e.haz = ehz;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    pipe_regwrite_in = 1'b0; pipe_rd_in = 5'd0; pipe_wdata_in = 32'd0;
    mdu_valid_in = 1'b0; mdu_rd_in = 5'd0; mdu_wdata_in = 32'd0;
    chk_rs1_in = 5'd0; chk_rs2_in = 5'd0; chk_rd_in = 5'd0;

    //   tag            rs  pw prd pd          mv mrd md             c1  c2 c3  we a   d              st c  rdy hz
    cyc("rst",           1,  0, 0, 32'h0,       1, 5, 32'hA5A5A5A5,  0,  0, 0,  0, 0, 32'h0,         0, 0, 0, 0);
    cyc("byp",           0,  0, 0, 32'h0,       1, 5, 32'hA5A5A5A5,  5,  0, 0,  1, 5, 32'hA5A5A5A5,  0, 0, 1, 0);
    cyc("byp_cnt",       0,  0, 0, 32'h0,       0, 0, 32'h0,         5,  0, 0,  0, 0, 32'h0,         0, 0, 1, 0);
    cyc("mdu_rd0",       0,  0, 0, 32'h0,       1, 0, 32'h123,       0,  0, 0,  0, 0, 32'h0,         0, 0, 1, 0);
    cyc("pipe_rd0",      0,  1, 0, 32'hDEAD,    0, 0, 32'h0,         0,  0, 0,  0, 0, 32'h0,         0, 0, 1, 0);
    cyc("fill7",         0,  1, 3, 32'h33,      1, 7, 32'h77,        0,  0, 0,  1, 3, 32'h33,        0, 0, 1, 0);
    cyc("fill8",         0,  1, 3, 32'h34,      1, 8, 32'h88,        7,  0, 0,  1, 3, 32'h34,        0, 1, 1, 1);
    cyc("full",          0,  1, 3, 32'h35,      1, 9, 32'h99,        7,  0, 0,  1, 3, 32'h35,        0, 2, 0, 1);
    cyc("deny_last",     0,  1, 3, 32'h36,      1, 9, 32'h99,        0,  8, 0,  1, 3, 32'h36,        0, 2, 0, 1);
    cyc("starve7",       0,  1, 3, 32'h37,      1, 9, 32'h99,        0,  0, 8,  1, 7, 32'h77,        1, 2, 0, 1);
    cyc("pipe_resume",   0,  1, 3, 32'h37,      1, 9, 32'h99,        0,  0, 0,  1, 3, 32'h37,        0, 1, 1, 0);
    cyc("deny8_a",       0,  1, 3, 32'h38,      0, 0, 32'h0,         0,  0, 0,  1, 3, 32'h38,        0, 2, 0, 0);
    cyc("deny8_b",       0,  1, 3, 32'h39,      0, 0, 32'h0,         0,  0, 0,  1, 3, 32'h39,        0, 2, 0, 0);
    cyc("starve8",       0,  1, 3, 32'h3A,      0, 0, 32'h0,         0,  0, 0,  1, 8, 32'h88,        1, 2, 0, 0);
    cyc("head_push",     0,  0, 0, 32'h0,       1, 12, 32'hCC,       0,  0, 0,  1, 9, 32'h99,        0, 1, 1, 0);
    cyc("order",         0,  0, 0, 32'h0,       0, 0, 32'h0,         12, 0, 0,  1, 12, 32'hCC,       0, 1, 1, 1);
    cyc("fill17",        0,  1, 3, 32'h40,      1, 17, 32'h1111,     0,  0, 0,  1, 3, 32'h40,        0, 0, 1, 0);
    cyc("rd0_busy",      0,  1, 3, 32'h41,      1, 0, 32'hBAD,       0,  0, 0,  1, 3, 32'h41,        0, 1, 1, 0);
    cyc("fill18",        0,  1, 3, 32'h42,      1, 18, 32'h1212,     0,  0, 0,  1, 3, 32'h42,        0, 1, 1, 0);
    cyc("rst_mid",       1,  1, 3, 32'h43,      0, 0, 32'h0,         17, 0, 0,  0, 0, 32'h0,         0, 0, 0, 0);
    cyc("post_rst",      0,  0, 0, 32'h0,       0, 0, 32'h0,         17, 0, 0,  0, 0, 32'h0,         0, 0, 1, 0);
    cyc("post_rst_pipe", 0,  1, 4, 32'h44,      0, 0, 32'h0,         18, 0, 0,  1, 4, 32'h44,        0, 0, 1, 0);

    @(negedge clk);
    #4;
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 8, number of consecutive denied cycles of the buffered result before it is forced onto the write port (legal 2..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 pipe_regwrite_in  input  1  write request from WB stage.
REQ-005 pipe_rd_in  input  5  WB destination register.
REQ-006 pipe_wdata_in  input  32  WB write data.
REQ-007 mdu_valid_in  input  1  multi-cycle unit result valid.
REQ-008 mdu_rd_in  input  5  multi-cycle unit destination register.
REQ-009 mdu_wdata_in  input  32  multi-cycle unit result data.
REQ-010 mdu_ready_out  output  1  arbiter accepts an MDU result this cycle.
REQ-011 chk_rs1_in, chk_rs2_in, chk_rd_in  input  5 each  decode-stage register numbers for hazard check.
REQ-012 hazard_out  output  1  a buffered MDU result targets a checked register; decode stalls.
REQ-013 pipe_stall_out  output  1  WB request not granted this cycle; pipeline holds WB inputs stable.
REQ-014 rf_we_out  output  1  register-file write enable.
REQ-015 rf_waddr_out  output  5  register-file write address.
REQ-016 rf_wdata_out  output  32  register-file write data.
REQ-017 pending_count_out  output  2  buffered MDU results (0..2).

Function
REQ-018 The block SHALL contain a 2-entry FIFO (rd, data) for MDU results, a 2-bit count, and a starvation counter; all other outputs are combinational from state and inputs.
REQ-019 A pipe request is effective only when pipe_regwrite_in=1 and pipe_rd_in!=0.
REQ-020 mdu_ready_out SHALL be 1 when count<2, else 0; an MDU handshake occurs when mdu_valid_in=1 and mdu_ready_out=1.
REQ-021 An accepted MDU result with mdu_rd_in=0 SHALL be consumed and discarded (no write, no push).
REQ-022 Grant priority per cycle: (a) FIFO head if starvation counter = STARVE_LIMIT-1 and FIFO non-empty; (b) effective pipe request; (c) FIFO head if non-empty; (d) bypass of the current MDU handshake if FIFO empty; (e) no write.
REQ-023 The granted source drives rf_we_out=1, rf_waddr_out, rf_wdata_out in the same cycle (zero latency); with no grant rf_we_out=0 and address/data are 0.
REQ-024 A granted FIFO head SHALL pop at the clock edge; an accepted nonzero-rd MDU result not bypassed SHALL push at the same edge; simultaneous push and pop keeps count unchanged and preserves order.
REQ-025 pipe_stall_out SHALL be 1 only when an effective pipe request exists and grant (a) is taken.
REQ-026 Starvation counter SHALL increment when FIFO non-empty and head not granted, clear on any pop or when FIFO empty, and never exceed STARVE_LIMIT-1.
REQ-027 hazard_out SHALL be 1 when any valid FIFO entry has rd equal to a nonzero chk_rs1_in, chk_rs2_in or chk_rd_in; bypassed results never raise hazard_out.
REQ-028 pending_count_out SHALL equal the current count register.

Reset
REQ-029 While reset=1: FIFO empty, count=0, starvation counter=0, rf_we_out=0, mdu_ready_out=0, pipe_stall_out=0, hazard_out=0, pending_count_out=0.
REQ-030 Reset asserted mid-operation SHALL discard buffered entries without writing them; first grant is possible in the first cycle after deassertion.

Verification
REQ-031 Idle FIFO, mdu_valid_in=1, rd=5, data=0xA5A5A5A5, no pipe request -> same cycle rf_we_out=1, waddr=5, wdata=0xA5A5A5A5, count stays 0.
REQ-032 Pipe writes rd=3 every cycle while MDU delivers rd=7 then rd=8 -> both buffered, count=2, mdu_ready_out=0, hazard_out=1 for chk_rs1_in=7.
REQ-033 Count=2, pipe continuously active -> after STARVE_LIMIT-1 denied cycles the next cycle writes rd=7 with pipe_stall_out=1; counter clears; rd=8 follows after another STARVE_LIMIT-1 denied cycles.
REQ-034 Count=1, no pipe request, MDU delivers rd=9 -> head written, rd=9 pushed, count remains 1, order preserved.
REQ-035 MDU result with rd=0, FIFO empty or not -> rf_we_out stays 0 for it, count unchanged; pipe_rd_in=0 with regwrite=1 -> no write.
REQ-036 Count=2, reset pulsed asynchronously mid-cycle -> outputs immediately reset values; after release count=0, mdu_ready_out=1, no stale writes.
